// File: rtl/cmp_sort_ctrl_pkg.sv
// rtl/cmp_sort_ctrl_pkg.sv - shared types and constants for the frame sorter
package cmp_sort_pkg;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      SORT  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int DEPTH_DEFAULT = 8;
   localparam int PTR_W         = $clog2(DEPTH_DEFAULT);
   localparam int DATA_W        = 8;

endpackage

// File: rtl/cmp_sort_ctrl_if.sv
// rtl/cmp_sort_ctrl_if.sv - input/output byte streams and busy flag of the frame sorter
interface cmp_sort_ctrl_if;
   import cmp_sort_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              busy;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );

endinterface

// File: rtl/cmp_sort_ctrl_cmp8.sv
// rtl/cmp_sort_ctrl_cmp8.sv - unsigned 8-bit magnitude comparator
module cmp8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       eq,
   output logic       gt,
   output logic       lt
);

   assign eq = (a == b);
   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - load/bubble-sort/drain controller sharing one cmp8
// CMP_SORT_DESC_EN: when defined, frames are sorted descending instead of ascending.
module cmp_sort_ctrl
   import cmp_sort_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   cmp_sort_ctrl_if.slave  bus
);

   localparam int IW = $clog2(DEPTH);
   localparam int LW = IW + 1;

   state_t            state;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [LW-1:0]     wr_ptr;   // holds the frame length once LOAD ends
   logic [IW-1:0]     rd_ptr;
   logic [IW-1:0]     j;
   logic [IW-1:0]     pass;
   logic              swapped;

   logic [IW-1:0]     j_nxt;
   logic [LW-1:0]     wr_cnt;
   logic              eq, gt, lt, swap;
   logic              in_hs, out_hs, frame_end, last_cmp, sort_done, drain_last;

   cmp8 u_cmp (
      .a  (mem[j]),
      .b  (mem[j_nxt]),
      .eq (eq),
      .gt (gt),
      .lt (lt)
   );

`ifdef CMP_SORT_DESC_EN
   assign swap = ~eq & lt & ~gt;
`else
   assign swap = ~eq & gt & ~lt;
`endif

   assign j_nxt      = j + IW'(1);
   assign wr_cnt     = wr_ptr + LW'(1);
   assign in_hs      = (state == LOAD) && bus.in_valid;
   assign out_hs     = (state == DRAIN) && bus.out_ready;
   assign frame_end  = bus.in_last || (wr_cnt == LW'(DEPTH));
   assign last_cmp   = (LW'(j) == wr_ptr - LW'(2) - LW'(pass));
   // A swap on the final compare of a pass still forces another pass.
   assign sort_done  = !(swapped || swap) || (LW'(pass) == wr_ptr - LW'(2));
   assign drain_last = (LW'(rd_ptr) == wr_ptr - LW'(1));

   assign bus.in_ready  = (state == LOAD);
   assign bus.out_valid = (state == DRAIN);
   assign bus.busy      = (state != LOAD);
   assign bus.out_data  = (state == DRAIN) ? mem[rd_ptr] : '0;
   assign bus.out_last  = (state == DRAIN) && drain_last;

   always_ff @(posedge clk) begin
      if (in_hs) begin
         mem[wr_ptr[IW-1:0]] <= bus.in_data;
      end else if ((state == SORT) && swap) begin
         mem[j]     <= mem[j_nxt];
         mem[j_nxt] <= mem[j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= LOAD;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         j       <= '0;
         pass    <= '0;
         swapped <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (in_hs) begin
                  wr_ptr <= wr_cnt;
                  if (frame_end) begin
                     j       <= '0;
                     pass    <= '0;
                     swapped <= 1'b0;
                     rd_ptr  <= '0;
                     state   <= (wr_cnt == LW'(1)) ? DRAIN : SORT;
                  end
               end
            end
            SORT: begin
               if (last_cmp) begin
                  if (sort_done) begin
                     state <= DRAIN;
                  end else begin
                     pass    <= pass + IW'(1);
                     j       <= '0;
                     swapped <= 1'b0;
                  end
               end else begin
                  j       <= j_nxt;
                  swapped <= swapped | swap;
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  if (drain_last) begin
                     state  <= LOAD;
                     wr_ptr <= '0;
                     rd_ptr <= '0;
                  end else begin
                     rd_ptr <= rd_ptr + IW'(1);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// tb/tb_cmp_sort_ctrl.sv - randomized self-checking bench for cmp_sort_ctrl against a frame-level model
module tb_cmp_sort_ctrl;

   localparam int DEPTH = 8;
`ifdef CMP_SORT_DESC_EN
   localparam bit DESC = 1'b1;
`else
   localparam bit DESC = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cmp_sort_ctrl_if bus ();

   cmp_sort_ctrl #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef enum {M_LOAD, M_SORT, M_DRAIN} mphase_t;

   mphase_t      ph = M_LOAD;
   byte unsigned frame[$];
   byte unsigned expq[$];
   byte unsigned got[$];
   int           sort_left = 0;
   int           sort_cnt  = 0;
   int           n_pass    = 0;
   int           n_chk     = 0;
   bit           prev_stall = 1'b0;
   logic [7:0]   prev_data  = 8'h00;
   logic         prev_last  = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   function automatic bit out_of_order(input byte unsigned a, input byte unsigned b);
      return DESC ? (a < b) : (a > b);
   endfunction

   // Frame-level model: sorted result and number of compare cycles.
   task automatic model_frame_end();
      int           n;
      int           cyc;
      bit           sw;
      byte unsigned t;
      n   = frame.size();
      cyc = 0;
      expq = frame;
      for (int p = 0; p <= n - 2; p++) begin
         sw = 1'b0;
         for (int k = 0; k <= n - 2 - p; k++) begin
            cyc++;
            if (out_of_order(expq[k], expq[k+1])) begin
               t = expq[k]; expq[k] = expq[k+1]; expq[k+1] = t;
               sw = 1'b1;
            end
         end
         if (!sw) break;
      end
      if (n == 1) ph = M_DRAIN;
      else begin
         ph = M_SORT;
         sort_left = cyc;
      end
   endtask

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         ph = M_LOAD;
         frame.delete();
         expq.delete();
      end else begin
         case (ph)
            M_LOAD: if (bus.in_valid) begin
               frame.push_back(bus.in_data);
               if (bus.in_last || frame.size() == DEPTH) model_frame_end();
            end
            M_SORT: begin
               sort_left--;
               if (sort_left == 0) ph = M_DRAIN;
            end
            M_DRAIN: if (bus.out_ready) begin
               void'(expq.pop_front());
               if (expq.size() == 0) begin
                  ph = M_LOAD;
                  frame.delete();
               end
            end
            default: ph = M_LOAD;
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         chk("rst_in_ready",  bus.in_ready,  1);
         chk("rst_out_valid", bus.out_valid, 0);
         chk("rst_out_data",  bus.out_data,  0);
         chk("rst_out_last",  bus.out_last,  0);
         chk("rst_busy",      bus.busy,      0);
         prev_stall = 1'b0;
      end else begin
         chk("in_ready",  bus.in_ready,  ph == M_LOAD);
         chk("out_valid", bus.out_valid, ph == M_DRAIN);
         chk("busy",      bus.busy,      ph != M_LOAD);
         if (ph == M_DRAIN && expq.size() > 0) begin
            chk("out_data", bus.out_data, expq[0]);
            chk("out_last", bus.out_last, expq.size() == 1);
         end
         if (prev_stall) begin
            chk("hold_data", bus.out_data, prev_data);
            chk("hold_last", bus.out_last, prev_last);
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_last  = bus.out_last;
         if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
         if (bus.busy && !bus.out_valid) sort_cnt++;
      end
   end

   task automatic send_frame(input byte unsigned vals[$], input bit use_last);
      chk("start_in_load", ph == M_LOAD, 1);
      got.delete();
      sort_cnt = 0;
      for (int i = 0; i < vals.size(); i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = vals[i];
         bus.in_last  = use_last && (i == vals.size() - 1);
         @(posedge clk); #2;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic run_frame(input byte unsigned vals[$], input bit use_last, input bit bp);
      int n_out;
      n_out = vals.size();
      send_frame(vals, use_last);
      for (int c = 0; c < 2000; c++) begin
         if (ph == M_LOAD && got.size() >= n_out) break;
         bus.out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
         @(posedge clk); #2;
      end
      bus.out_ready = 1'b1;
      chk("frame_done", (ph == M_LOAD) && (got.size() == n_out), 1);
   endtask

   task automatic expect_got(input string name, input byte unsigned exp[$]);
      chk({name, "_len"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++) chk(name, got[i], exp[i]);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      byte unsigned q[$];
      byte unsigned e[$];
      int           len;
      bit           ul;

      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;

      q = {8'd200, 8'd10, 8'd120};
      run_frame(q, 1'b1, 1'b0);
      if (DESC) e = {8'd200, 8'd120, 8'd10}; else e = {8'd10, 8'd120, 8'd200};
      expect_got("f3", e);
      chk("f3_sort_cycles", sort_cnt, 3);

      q = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      run_frame(q, 1'b1, 1'b0);
      if (DESC) e = q; else e = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      expect_got("rev", e);
      chk("rev_sort_cycles", sort_cnt, DESC ? 7 : 28);

      q = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      run_frame(q, 1'b1, 1'b0);
      if (DESC) e = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}; else e = q;
      expect_got("fwd", e);
      chk("fwd_sort_cycles", sort_cnt, DESC ? 28 : 7);

      q = {8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255};
      run_frame(q, 1'b0, 1'b0);
      expect_got("ff", q);
      chk("ff_sort_cycles", sort_cnt, 7);

      q = {8'd42};
      run_frame(q, 1'b1, 1'b0);
      expect_got("one", q);
      chk("one_sort_cycles", sort_cnt, 0);

      q = {8'd10, 8'd20, 8'd0, 8'd255};
      run_frame(q, 1'b1, 1'b1);
      if (DESC) e = {8'd255, 8'd20, 8'd10, 8'd0}; else e = {8'd0, 8'd10, 8'd20, 8'd255};
      expect_got("bp", e);

      q = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      send_frame(q, 1'b1);
      repeat (2) @(posedge clk);
      #2 chk("mid_sort_busy", bus.busy, 1);
      rst_n = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
      q = {8'd5, 8'd3};
      run_frame(q, 1'b1, 1'b0);
      if (DESC) e = {8'd5, 8'd3}; else e = {8'd3, 8'd5};
      expect_got("post_rst", e);
      chk("post_rst_sort_cycles", sort_cnt, 1);

      for (int f = 0; f < 30; f++) begin
         len = $urandom_range(1, DEPTH);
         ul  = (len < DEPTH) ? 1'b1 : ($urandom_range(0, 1) == 1);
         q.delete();
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 1) == 1) q.push_back(8'($urandom_range(0, 3) * 85));
            else q.push_back(8'($urandom_range(0, 255)));
         end
         run_frame(q, ul, $urandom_range(0, 1) == 1);
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
